maxpool_relu_stream: RTL and testbench
======================================

// Module: maxpool_relu_stream
// PURPOSE
//  Streaming KxK max-pool (stride K) with optional ReLU on signed fixed-point feature-map data.
//  LANES channels are pooled in parallel, one pixel per beat, raster order.
//  Generalises the fixed 4-input max / ReLU pair: window, image size and lanes are parameters, input is a stream.
//  Sits between a conv/accumulate stage and the next layer's input stream.
// PARAMETERS
//  DW     22  data width per lane (signed, FPSHIFT=14 fraction; pooling is scale-free)
//  LANES  1   parallel channels per beat
//  K      2   pool window side and stride (2..4)
//  IMG_W  28  input frame width in pixels; must be a multiple of K
//  IMG_H  28  input frame height in pixels; must be a multiple of K
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         async active-low reset
//  relu_en    in   1         1: out = max(pool,0); 0: raw pool; held stable within a frame
//  in_valid   in   1         input beat valid
//  in_ready   out  1         input beat accepted when in_valid & in_ready
//  in_data    in   LANES*DW  lane i at [i*DW +: DW], signed
//  out_valid  out  1         pooled beat valid
//  out_ready  in   1         downstream accepts when out_valid & out_ready
//  out_data   out  LANES*DW  pooled (+ReLU) lanes, same packing
//  out_last   out  1         high with last pooled beat of frame ((IMG_W/K)*(IMG_H/K)-th)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, out_last=0, col=row=0, h_acc=0; line buffer not cleared (always overwritten before read).
//  in_ready = !out_valid | out_ready (combinational; one-entry output register).
//  Per accepted beat, per lane: kx=col%K, ky=row%K, slot=col/K
//   kx==0: h_acc<=in; else h=max(h_acc,in) (signed compare), h_acc<=h.
//   kx==K-1 (window row complete, value h):
//    ky==0: buf[slot]<=h;  0<ky<K-1: buf[slot]<=max(buf[slot],h);
//    ky==K-1: p=max(buf[slot],h); out_data<=relu_en&p<0 ? 0 : p; out_valid<=1.
//  Counters: col 0..IMG_W-1; at IMG_W-1 col<=0,row++; at last pixel row<=0 (next frame, no gap).
//  Latency: pooled beat registered 1 cycle after the accepting beat that closes the window.
//  out_valid cleared on out_ready handshake unless a new pooled beat loads the same cycle (then stays 1).
//  Backpressure: with out_valid&!out_ready, in_ready=0, all state frozen; no data lost/duplicated.
//  Ties: equal values → either; same bits. Most-negative input (-2^(DW-1)) handled; no saturation, no width growth.
//  ReLU = sign-bit test: MSB=1 → 0; zero passes unchanged.
//  Reset mid-frame: partial windows discarded; next accepted beat is pixel (0,0) of a new frame.
//  IMG_W%K!=0 or IMG_H%K!=0: elaboration error (generate-time $error).
// STRUCTURE
//  Shared package dsp_pkg: DATSIZE=22, PARSIZE=16, FPSHIFT=14 constants; function smax(a,b) signed max.
//  Sub-module pool_line_buf: IMG_W/K x LANES*DW reg array, comb read at slot, sync write; no reset.
//  Top: col/row counters, h_acc per lane, compare/relu datapath (generate over LANES), output register.
// TESTING
//  K=2,W=H=4,LANES=1, relu_en=0, in = 0..15 raster → out 5,7,13,15; out_last on 15 only.
//  Same frame negated (0..-15), relu_en=1 → out 0,0,0,0; relu_en=0 → -0,-2,-8,-10.
//  Extremes: window {-2^21, 2^21-1, -1, 0} → 2^21-1; all -2^21 → -2^21 (relu_en=0).
//  Backpressure: out_ready low 5 cycles with out_valid high → in_ready=0, output held; resumes, sequence unchanged.
//  Reset asserted after 6 beats, then full frame 0..15 → exactly 4 outputs 5,7,13,15.
//  LANES=2,K=3,W=H=6: lane0=pixel idx, lane1=-idx → lane0 out 14,17,32,35; lane1 out -0,-3,-18,-21; back-to-back frames no gap.

Source files
------------

// File: rtl/dsp_pkg.sv
// Shared DSP datapath package.
// Holds the fixed-point format constants used across the conv/pool chain and
// a signed max helper. The helper works on 64-bit signed operands so that
// modules with any data width up to 64 bits can share it by sign-extending
// their operands and truncating the result.
package dsp_pkg;

  localparam int DATSIZE = 22;  // default datapath word width
  localparam int PARSIZE = 16;  // coefficient / parameter word width
  localparam int FPSHIFT = 14;  // fraction bits of the fixed-point format

  // Signed maximum. On a tie either operand is returned; both have the same bits.
  function automatic logic signed [63:0] smax(input logic signed [63:0] a,
                                              input logic signed [63:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_relu_stream_line_buf.sv
// pool_line_buf: one entry per pooling-window column slot, holding the running
// vertical max of the window rows already completed.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe (synchronous)
//   addr     in   slot index, shared by read and write
//   wr_data  in   packed lanes to store
//   rd_data  out  packed lanes at addr (combinational read)
// No reset: every slot is written on the first window row of a window band
// before it is ever read.
module pool_line_buf #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 22,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/maxpool_relu_stream.sv
// maxpool_relu_stream: streaming KxK max-pool (stride K) with optional ReLU on
// signed fixed-point data, LANES channels per beat, pixels in raster order.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   relu_en              1: clamp negative pooled values to 0; hold within a frame
//   in_valid/in_ready    input handshake; in_data lane i at [i*DW +: DW]
//   out_valid/out_ready  output handshake; out_data uses the same packing
//   out_last             marks the final pooled beat of a frame
// The horizontal max of the current window row is kept in h_acc; completed
// window rows are folded into the line buffer per column slot; the last window
// row produces the pooled beat into a one-entry output register.
module maxpool_relu_stream
  import dsp_pkg::*;
#(
  parameter int DW    = DATSIZE,
  parameter int LANES = 1,
  parameter int K     = 2,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                relu_en,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_data,
  output logic                out_last
);

  localparam int SLOTS = IMG_W / K;
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int KW    = $clog2(K);
  localparam int LW    = LANES * DW;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(K - 1);

  if ((IMG_W % K) != 0 || (IMG_H % K) != 0) begin : g_bad_geometry
    $error("maxpool_relu_stream: IMG_W and IMG_H must be multiples of K");
  end
  if (K < 2 || K > 4) begin : g_bad_window
    $error("maxpool_relu_stream: K must be in 2..4");
  end

  function automatic logic signed [DW-1:0] max_dw(input logic signed [DW-1:0] a,
                                                  input logic signed [DW-1:0] b);
    logic signed [63:0] m;
    m = smax(64'(a), 64'(b));
    return m[DW-1:0];
  endfunction

  // Sign-bit test only: zero and positives pass through unchanged.
  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v,
                                                input logic en);
    return (en && v[DW-1]) ? '0 : v;
  endfunction

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [KW-1:0] kx_q, kx_d;
  logic [KW-1:0] ky_q, ky_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [LW-1:0] h_acc_q, h_acc_d;
  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] out_data_q, out_data_d;
  logic          out_last_q, out_last_d;

  logic          accept;
  logic          win_end;
  logic          win_close;
  logic          buf_we;
  logic [LW-1:0] buf_rd;
  logic [LW-1:0] buf_wr;
  logic [LW-1:0] h_vec;
  logic [LW-1:0] pool_vec;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign win_end   = (kx_q == K_LAST);
  assign win_close = win_end && (ky_q == K_LAST);

  pool_line_buf #(
    .DEPTH (SLOTS),
    .WIDTH (LW),
    .AW    (SW)
  ) u_line_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .addr    (slot_q),
    .wr_data (buf_wr),
    .rd_data (buf_rd)
  );

  // Per-lane compare / ReLU datapath
  always_comb begin
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] h;
    logic signed [DW-1:0] v;
    h_vec    = '0;
    pool_vec = '0;
    buf_wr   = '0;
    for (int i = 0; i < LANES; i++) begin
      x = in_data[i*DW +: DW];
      h = (kx_q == '0) ? x : max_dw(h_acc_q[i*DW +: DW], x);
      v = max_dw(buf_rd[i*DW +: DW], h);
      h_vec[i*DW +: DW]    = h;
      buf_wr[i*DW +: DW]   = (ky_q == '0) ? h : v;
      pool_vec[i*DW +: DW] = relu(v, relu_en);
    end
  end

  // Counters, accumulators and output register next-state
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    kx_d        = kx_q;
    ky_d        = ky_q;
    slot_d      = slot_q;
    h_acc_d     = h_acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    buf_we      = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      h_acc_d = h_vec;
      buf_we  = win_end && (ky_q != K_LAST);

      if (win_close) begin
        out_data_d  = pool_vec;
        out_valid_d = 1'b1;
        out_last_d  = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end

      kx_d = win_end ? '0 : kx_q + KW'(1);
      if (win_end) begin
        slot_d = slot_q + SW'(1);
      end

      // IMG_W is a multiple of K, so kx wraps on its own at end of line.
      if (col_q == COL_LAST) begin
        col_d  = '0;
        slot_d = '0;
        ky_d   = (ky_q == K_LAST) ? '0 : ky_q + KW'(1);
        if (row_q == ROW_LAST) begin
          row_d = '0;
          ky_d  = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      kx_q        <= '0;
      ky_q        <= '0;
      slot_q      <= '0;
      h_acc_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      kx_q        <= kx_d;
      ky_q        <= ky_d;
      slot_q      <= slot_d;
      h_acc_q     <= h_acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_maxpool_relu_stream.sv
module tb_maxpool_relu_stream;

  localparam int DW = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // DUT A: K=2, 4x4, one lane
  logic          relu_a, iv_a, ir_a, ov_a, or_a, ol_a;
  logic [DW-1:0] id_a, od_a;
  // DUT B: K=3, 6x6, two lanes
  logic            relu_b, iv_b, ir_b, ov_b, or_b, ol_b;
  logic [2*DW-1:0] id_b, od_b;

  maxpool_relu_stream #(.DW(DW), .LANES(1), .K(2), .IMG_W(4), .IMG_H(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .relu_en(relu_a),
    .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a),
    .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_last(ol_a)
  );

  maxpool_relu_stream #(.DW(DW), .LANES(2), .K(3), .IMG_W(6), .IMG_H(6)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .relu_en(relu_b),
    .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b),
    .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_last(ol_b)
  );

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] qa_d[$];
  logic                 qa_l[$];
  logic signed [DW-1:0] qb0[$];
  logic signed [DW-1:0] qb1[$];
  logic                 qb_l[$];

  int fa[16];

  // Output capture: a beat seen valid&ready at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n && ov_a && or_a) begin
      qa_d.push_back(od_a);
      qa_l.push_back(ol_a);
    end
    if (rst_n && ov_b && or_b) begin
      qb0.push_back(od_b[DW-1:0]);
      qb1.push_back(od_b[2*DW-1:DW]);
      qb_l.push_back(ol_b);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_a(input int v);
    int n;
    iv_a = 1'b1;
    id_a = DW'(v);
    n = 0;
    @(negedge clk);
    while (!ir_a && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_a_bound", n, 0);
    @(posedge clk);
    #1;
    iv_a = 1'b0;
  endtask

  task automatic send_b(input int v);
    int n;
    iv_b = 1'b1;
    id_b = {DW'(-v), DW'(v)};
    n = 0;
    @(negedge clk);
    while (!ir_b && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("send_b_bound", n, 0);
    @(posedge clk);
    #1;
    iv_b = 1'b0;
  endtask

  task automatic send_frame_a();
    for (int i = 0; i < 16; i++) send_a(fa[i]);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input int e0, input int e1,
                          input int e2, input int e3);
    int e[4];
    logic signed [DW-1:0] d;
    logic l;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk({tag, "_count"}, qa_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (qa_d.size() > 0) begin
        d = qa_d.pop_front();
        l = qa_l.pop_front();
        chk($sformatf("%s_data%0d", tag, i), d, e[i]);
        chk($sformatf("%s_last%0d", tag, i), {31'd0, l}, (i == 3) ? 1 : 0);
      end
    end
    qa_d.delete();
    qa_l.delete();
  endtask

  initial begin
    int e0[4];
    int e1[4];
    logic signed [DW-1:0] d;
    logic l;

    rst_n  = 1'b0;
    relu_a = 1'b0; iv_a = 1'b0; id_a = '0; or_a = 1'b1;
    relu_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, ov_a}, 0);
    chk("rst_out_data", od_a, 0);
    chk("rst_out_last", {31'd0, ol_a}, 0);
    chk("rst_in_ready", {31'd0, ir_a}, 1);
    chk("rst_b_out_valid", {31'd0, ov_b}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp 0..15, raw pool
    for (int i = 0; i < 16; i++) fa[i] = i;
    send_frame_a();
    drain();
    expect_a("ramp", 5, 7, 13, 15);

    // Negated ramp with ReLU, then without
    for (int i = 0; i < 16; i++) fa[i] = -i;
    relu_a = 1'b1;
    send_frame_a();
    drain();
    expect_a("neg_relu", 0, 0, 0, 0);
    relu_a = 1'b0;
    send_frame_a();
    drain();
    expect_a("neg_raw", 0, -2, -8, -10);

    // Extreme values
    for (int i = 0; i < 16; i++) fa[i] = 0;
    fa[0] = -(1 << 21); fa[1] = (1 << 21) - 1; fa[4] = -1; fa[5] = 0;
    fa[2] = -(1 << 21); fa[3] = -(1 << 21); fa[6] = -(1 << 21); fa[7] = -(1 << 21);
    send_frame_a();
    drain();
    expect_a("extreme", (1 << 21) - 1, -(1 << 21), 0, 0);

    // Backpressure: hold the first pooled beat for 5 cycles
    or_a = 1'b0;
    for (int i = 0; i < 6; i++) send_a(i);
    iv_a = 1'b1;
    id_a = DW'(6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_out_valid%0d", c), {31'd0, ov_a}, 1);
      chk($sformatf("bp_in_ready%0d", c), {31'd0, ir_a}, 0);
      chk($sformatf("bp_out_data%0d", c), $signed(od_a), 5);
    end
    @(posedge clk);
    #1;
    iv_a = 1'b0;
    or_a = 1'b1;
    for (int i = 6; i < 16; i++) send_a(i);
    drain();
    expect_a("bp", 5, 7, 13, 15);

    // Reset in the middle of a frame
    for (int i = 0; i < 6; i++) send_a(i);
    drain();
    rst_n = 1'b0;
    #3;
    chk("midrst_out_valid", {31'd0, ov_a}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    qa_d.delete();
    qa_l.delete();
    for (int i = 0; i < 16; i++) fa[i] = i;
    send_frame_a();
    drain();
    expect_a("midrst", 5, 7, 13, 15);

    // Two lanes, K=3, two frames back to back
    e0[0] = 14; e0[1] = 17; e0[2] = 32;  e0[3] = 35;
    e1[0] = 0;  e1[1] = -3; e1[2] = -18; e1[3] = -21;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 36; i++) send_b(i);
    end
    drain();
    chk("lanes_count", qb0.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (qb0.size() > 0) begin
        d = qb0.pop_front();
        chk($sformatf("lane0_data%0d", k), d, e0[k % 4]);
        d = qb1.pop_front();
        chk($sformatf("lane1_data%0d", k), d, e1[k % 4]);
        l = qb_l.pop_front();
        chk($sformatf("lanes_last%0d", k), {31'd0, l}, (k % 4 == 3) ? 1 : 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
